// File: rtl/mmu_xlate_seq.sv
// rtl/mmu_xlate_seq.sv - MMU translation sequencer between the BAT checker and the TLB
//
// Holds one translation request at a time. The captured request feeds the
// combinational BAT checker. On a BAT hit that result is returned. On a miss a
// TLB/page-table lookup is issued and its result is returned. With translation
// off, an identity (real-mode) result is returned.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_*                        request handshake and fields (valid/ready)
//   cancel                       pipeline flush of the in-flight request
//   bat_vaddr/privileged/rnw     captured request towards the BAT checker
//   bat_valid/paddr/cacheable/fault  BAT checker result
//   tlb_req/vaddr/rnw/priv       level-held lookup request towards the TLB
//   tlb_ack/paddr/cacheable/fault    one-cycle TLB result
//   resp_*                       translation response handshake and fields

module mmu_xlate_seq #(
    parameter int INSTRUCTION = 0,
    parameter int REGSZ       = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [REGSZ-1:0] req_vaddr,
    input  logic             req_rnw,
    input  logic             req_priv,
    input  logic             req_xlate_en,
    input  logic             cancel,

    output logic [REGSZ-1:0] bat_vaddr,
    output logic             bat_privileged,
    output logic             bat_rnw,
    input  logic             bat_valid,
    input  logic [REGSZ-1:0] bat_paddr,
    input  logic             bat_cacheable,
    input  logic [2:0]       bat_fault,

    output logic             tlb_req,
    output logic [REGSZ-1:0] tlb_vaddr,
    output logic             tlb_rnw,
    output logic             tlb_priv,
    input  logic             tlb_ack,
    input  logic [REGSZ-1:0] tlb_paddr,
    input  logic             tlb_cacheable,
    input  logic [2:0]       tlb_fault,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [REGSZ-1:0] resp_paddr,
    output logic             resp_cacheable,
    output logic [2:0]       resp_fault
);

    localparam logic [2:0] MMU_FAULT_NONE = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TLB_WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [REGSZ-1:0] cap_vaddr;
    logic             cap_priv;
    logic             cap_rnw;
    logic             cap_xlate;

    logic             accept;
    logic             load_real;
    logic             load_bat;
    logic             load_tlb;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // cancel is checked before any BAT/TLB result so a flushed request can
    // never load the response registers. A cancelled TLB lookup still waits
    // in DRAIN for its ack so the TLB handshake is never abandoned.
    always_comb begin
        state_nx  = state;
        load_real = 1'b0;
        load_bat  = 1'b0;
        load_tlb  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (!cap_xlate) begin
                    load_real = 1'b1;
                    state_nx  = RESP;
                end else if (bat_valid) begin
                    load_bat = 1'b1;
                    state_nx = RESP;
                end else begin
                    state_nx = TLB_WAIT;
                end
            end
            TLB_WAIT: begin
                if (cancel) begin
                    state_nx = tlb_ack ? IDLE : DRAIN;
                end else if (tlb_ack) begin
                    load_tlb = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (cancel || resp_ready) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (tlb_ack) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Captured request. The I-side only ever fetches, so direction is forced
    // to read there regardless of what the requester drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vaddr <= '0;
            cap_priv  <= 1'b0;
            cap_rnw   <= 1'b1;
            cap_xlate <= 1'b0;
        end else if (accept) begin
            cap_vaddr <= req_vaddr;
            cap_priv  <= req_priv;
            cap_rnw   <= (INSTRUCTION != 0) ? 1'b1 : req_rnw;
            cap_xlate <= req_xlate_en;
        end
    end

    // Response registers only change on a load, which keeps resp_* stable
    // for the whole time the response is being backpressured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_paddr     <= '0;
            resp_cacheable <= 1'b0;
            resp_fault     <= MMU_FAULT_NONE;
        end else if (load_real) begin
            resp_paddr     <= cap_vaddr;
            resp_cacheable <= 1'b1;
            resp_fault     <= MMU_FAULT_NONE;
        end else if (load_bat) begin
            resp_paddr     <= bat_paddr;
            resp_cacheable <= bat_cacheable;
            resp_fault     <= bat_fault;
        end else if (load_tlb) begin
            resp_paddr     <= tlb_paddr;
            resp_cacheable <= tlb_cacheable;
            resp_fault     <= tlb_fault;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    // DRAIN keeps the lookup request up so the TLB sees a normal completion.
    assign tlb_req    = (state == TLB_WAIT) || (state == DRAIN);

    assign bat_vaddr      = cap_vaddr;
    assign bat_privileged = cap_priv;
    assign bat_rnw        = cap_rnw;
    assign tlb_vaddr      = cap_vaddr;
    assign tlb_rnw        = cap_rnw;
    assign tlb_priv       = cap_priv;

endmodule

// File: tb/tb_mmu_xlate_seq.sv
// tb/tb_mmu_xlate_seq.sv - randomized self-checking bench for mmu_xlate_seq

module tb_mmu_xlate_seq;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_PF   = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_vaddr = '0;
    logic        req_rnw = 1'b1;
    logic        req_priv = 1'b0;
    logic        req_xlate_en = 1'b0;
    logic        cancel = 1'b0;
    logic        bat_valid = 1'b0;
    logic [31:0] bat_paddr = '0;
    logic        bat_cacheable = 1'b0;
    logic [2:0]  bat_fault = '0;
    logic        tlb_ack = 1'b0;
    logic [31:0] tlb_paddr = '0;
    logic        tlb_cacheable = 1'b0;
    logic [2:0]  tlb_fault = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready, bat_privileged, bat_rnw, tlb_req, tlb_rnw, tlb_priv;
    logic        resp_valid, resp_cacheable;
    logic [31:0] bat_vaddr, tlb_vaddr, resp_paddr;
    logic [2:0]  resp_fault;

    logic        i_req_ready, i_bat_privileged, i_bat_rnw, i_tlb_req, i_tlb_rnw, i_tlb_priv;
    logic        i_resp_valid, i_resp_cacheable;
    logic [31:0] i_bat_vaddr, i_tlb_vaddr, i_resp_paddr;
    logic [2:0]  i_resp_fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmu_xlate_seq #(.INSTRUCTION(0), .REGSZ(32)) dut_d (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_rnw(req_rnw), .req_priv(req_priv), .req_xlate_en(req_xlate_en),
        .cancel(cancel),
        .bat_vaddr(bat_vaddr), .bat_privileged(bat_privileged), .bat_rnw(bat_rnw),
        .bat_valid(bat_valid), .bat_paddr(bat_paddr), .bat_cacheable(bat_cacheable),
        .bat_fault(bat_fault),
        .tlb_req(tlb_req), .tlb_vaddr(tlb_vaddr), .tlb_rnw(tlb_rnw), .tlb_priv(tlb_priv),
        .tlb_ack(tlb_ack), .tlb_paddr(tlb_paddr), .tlb_cacheable(tlb_cacheable),
        .tlb_fault(tlb_fault),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_cacheable(resp_cacheable), .resp_fault(resp_fault)
    );

    mmu_xlate_seq #(.INSTRUCTION(1), .REGSZ(32)) dut_i (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(i_req_ready), .req_vaddr(req_vaddr),
        .req_rnw(req_rnw), .req_priv(req_priv), .req_xlate_en(req_xlate_en),
        .cancel(cancel),
        .bat_vaddr(i_bat_vaddr), .bat_privileged(i_bat_privileged), .bat_rnw(i_bat_rnw),
        .bat_valid(bat_valid), .bat_paddr(bat_paddr), .bat_cacheable(bat_cacheable),
        .bat_fault(bat_fault),
        .tlb_req(i_tlb_req), .tlb_vaddr(i_tlb_vaddr), .tlb_rnw(i_tlb_rnw), .tlb_priv(i_tlb_priv),
        .tlb_ack(tlb_ack), .tlb_paddr(tlb_paddr), .tlb_cacheable(tlb_cacheable),
        .tlb_fault(tlb_fault),
        .resp_valid(i_resp_valid), .resp_ready(resp_ready), .resp_paddr(i_resp_paddr),
        .resp_cacheable(i_resp_cacheable), .resp_fault(i_resp_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction description consumed by run_xact.
    logic [31:0] x_vaddr, x_bat_paddr, x_tlb_paddr;
    logic        x_rnw, x_priv, x_xlate, x_bat_hit, x_bat_c, x_tlb_c;
    logic [2:0]  x_bat_f, x_tlb_f;
    int          x_tlb_lat, x_bp, x_cmode, x_cancel_at;   // cmode: 0 none, 1 CHECK, 2 TLB_WAIT, 3 RESP

    task automatic run_xact();
        logic [31:0] e_pa;
        logic        e_c;
        logic [2:0]  e_f;
        bit          tlb_path;
        bit          cancelled;

        // Reference: real mode -> identity, BAT hit -> BAT result, else TLB result.
        tlb_path = x_xlate && !x_bat_hit;
        if (!x_xlate) begin
            e_pa = x_vaddr; e_c = 1'b1; e_f = F_NONE;
        end else if (x_bat_hit) begin
            e_pa = x_bat_paddr; e_c = x_bat_c; e_f = x_bat_f;
        end else begin
            e_pa = x_tlb_paddr; e_c = x_tlb_c; e_f = x_tlb_f;
        end

        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 1);
        req_valid     = 1'b1;
        req_vaddr     = x_vaddr;
        req_rnw       = x_rnw;
        req_priv      = x_priv;
        req_xlate_en  = x_xlate;
        cancel        = 1'($urandom_range(0, 1));     // must not block the accept
        resp_ready    = 1'($urandom_range(0, 1));     // ignored without resp_valid
        tlb_ack       = 1'b0;
        bat_valid     = x_bat_hit;
        bat_paddr     = x_bat_paddr;
        bat_cacheable = x_bat_c;
        bat_fault     = x_bat_f;
        tlb_paddr     = x_tlb_paddr;
        tlb_cacheable = x_tlb_c;
        tlb_fault     = x_tlb_f;

        @(negedge clk);                                // CHECK cycle
        req_valid    = 1'b0;
        req_vaddr    = $urandom;
        req_rnw      = 1'($urandom_range(0, 1));
        req_priv     = 1'($urandom_range(0, 1));
        req_xlate_en = 1'($urandom_range(0, 1));
        chk("bat_vaddr", bat_vaddr, x_vaddr);
        chk("bat_priv", 32'(bat_privileged), 32'(x_priv));
        chk("bat_rnw", 32'(bat_rnw), 32'(x_rnw));
        chk("i_bat_rnw", 32'(i_bat_rnw), 1);
        chk("check_tlb_req", 32'(tlb_req), 0);
        chk("check_resp_valid", 32'(resp_valid), 0);
        chk("check_req_ready", 32'(req_ready), 0);
        cancel     = (x_cmode == 1);
        resp_ready = 1'($urandom_range(0, 1));
        if (x_cmode == 1) begin
            @(negedge clk);
            cancel = 1'b0;
            chk("cck_req_ready", 32'(req_ready), 1);
            chk("cck_resp_valid", 32'(resp_valid), 0);
            chk("cck_tlb_req", 32'(tlb_req), 0);
            return;
        end

        cancelled = 1'b0;
        if (tlb_path) begin
            for (int i = 0; i <= x_tlb_lat; i++) begin
                @(negedge clk);
                cancel  = 1'b0;
                tlb_ack = 1'b0;
                chk("tlb_req_held", 32'(tlb_req), 1);
                chk("tlb_vaddr", tlb_vaddr, x_vaddr);
                chk("tlb_priv", 32'(tlb_priv), 32'(x_priv));
                chk("tlb_rnw", 32'(tlb_rnw), 32'(x_rnw));
                chk("i_tlb_rnw", 32'(i_tlb_rnw), 1);
                chk("wait_resp_valid", 32'(resp_valid), 0);
                chk("wait_req_ready", 32'(req_ready), 0);
                resp_ready = 1'($urandom_range(0, 1));
                if (x_cmode == 2 && i == x_cancel_at) begin
                    cancel    = 1'b1;
                    cancelled = 1'b1;
                end
                if (i == x_tlb_lat) tlb_ack = 1'b1;
            end
        end

        @(negedge clk);
        cancel  = 1'b0;
        tlb_ack = 1'b0;
        if (cancelled) begin
            chk("drain_resp_valid", 32'(resp_valid), 0);
            chk("drain_req_ready", 32'(req_ready), 1);
            chk("drain_tlb_req", 32'(tlb_req), 0);
            return;
        end

        for (int b = 0; b <= x_bp; b++) begin
            chk("resp_valid", 32'(resp_valid), 1);
            chk("resp_paddr", resp_paddr, e_pa);
            chk("resp_cacheable", 32'(resp_cacheable), 32'(e_c));
            chk("resp_fault", 32'(resp_fault), 32'(e_f));
            chk("resp_req_ready", 32'(req_ready), 0);
            chk("resp_tlb_req", 32'(tlb_req), 0);
            if (b < x_bp) begin
                resp_ready = 1'b0;
                tlb_ack    = 1'($urandom_range(0, 1));   // stray ack must be ignored
                tlb_paddr  = $urandom;
                @(negedge clk);
                tlb_ack = 1'b0;
            end
        end
        if (x_cmode == 3) cancel = 1'b1;
        else resp_ready = 1'b1;
        @(negedge clk);
        cancel     = 1'b0;
        resp_ready = 1'b0;
        chk("done_resp_valid", 32'(resp_valid), 0);
        chk("done_req_ready", 32'(req_ready), 1);
    endtask

    task automatic clear_xact();
        x_vaddr = '0; x_rnw = 1'b1; x_priv = 1'b0; x_xlate = 1'b0; x_bat_hit = 1'b0;
        x_bat_paddr = '0; x_bat_c = 1'b0; x_bat_f = F_NONE;
        x_tlb_paddr = '0; x_tlb_c = 1'b0; x_tlb_f = F_NONE;
        x_tlb_lat = 0; x_bp = 0; x_cmode = 0; x_cancel_at = 0;
    endtask

    initial begin
        #12;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_tlb_req", 32'(tlb_req), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_paddr", resp_paddr, 0);
        chk("rst_resp_cacheable", 32'(resp_cacheable), 0);
        chk("rst_resp_fault", 32'(resp_fault), 32'(F_NONE));
        chk("rst_bat_vaddr", bat_vaddr, 0);
        chk("rst_bat_priv", 32'(bat_privileged), 0);
        chk("rst_bat_rnw", 32'(bat_rnw), 1);
        @(negedge clk);
        reset = 1'b0;

        // Real mode.
        clear_xact(); x_vaddr = 32'h1234_5678; x_rnw = 1'b0; run_xact();
        // BAT hit with a protection fault.
        clear_xact(); x_vaddr = 32'h0002_0004; x_xlate = 1'b1; x_bat_hit = 1'b1;
        x_bat_paddr = 32'h8002_0004; x_bat_c = 1'b0; x_bat_f = F_PF; run_xact();
        // BAT miss, TLB ack 5 cycles after tlb_req rises.
        clear_xact(); x_vaddr = 32'h0040_1000; x_xlate = 1'b1; x_priv = 1'b1;
        x_tlb_paddr = 32'h00AB_C000; x_tlb_c = 1'b1; x_tlb_lat = 5; run_xact();
        // Backpressure for 4 cycles.
        clear_xact(); x_vaddr = 32'hCAFE_0000; x_bp = 4; run_xact();
        // Cancel in TLB_WAIT, ack 3 cycles later.
        clear_xact(); x_vaddr = 32'h0000_3000; x_xlate = 1'b1; x_tlb_paddr = 32'h1111_0000;
        x_tlb_lat = 3; x_cmode = 2; x_cancel_at = 0; run_xact();
        // Cancel coincident with the TLB ack.
        clear_xact(); x_vaddr = 32'h0000_4000; x_xlate = 1'b1; x_tlb_lat = 2;
        x_cmode = 2; x_cancel_at = 2; run_xact();
        // Cancel in CHECK and in RESP.
        clear_xact(); x_vaddr = 32'h0000_5000; x_xlate = 1'b1; x_cmode = 1; run_xact();
        clear_xact(); x_vaddr = 32'h0000_6000; x_bp = 2; x_cmode = 3; run_xact();

        for (int t = 0; t < 60; t++) begin
            x_vaddr     = $urandom;
            x_rnw       = 1'($urandom_range(0, 1));
            x_priv      = 1'($urandom_range(0, 1));
            x_xlate     = ($urandom_range(0, 3) != 0);
            x_bat_hit   = 1'($urandom_range(0, 1));
            x_bat_paddr = $urandom;
            x_bat_c     = 1'($urandom_range(0, 1));
            x_bat_f     = 3'($urandom_range(0, 7));
            x_tlb_paddr = $urandom;
            x_tlb_c     = 1'($urandom_range(0, 1));
            x_tlb_f     = 3'($urandom_range(0, 7));
            x_tlb_lat   = $urandom_range(0, 6);
            x_bp        = $urandom_range(0, 3);
            x_cmode     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            x_cancel_at = $urandom_range(0, x_tlb_lat);
            if (x_cmode == 2 && !(x_xlate && !x_bat_hit)) x_cmode = 0;
            run_xact();
        end

        // Asynchronous reset while in TLB_WAIT, then a late ack.
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'h7777_0000; req_xlate_en = 1'b1;
        req_rnw = 1'b0; req_priv = 1'b1; bat_valid = 1'b0; cancel = 1'b0; tlb_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_tlb_req", 32'(tlb_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 1);
        chk("arst_tlb_req", 32'(tlb_req), 0);
        chk("arst_resp_valid", 32'(resp_valid), 0);
        chk("arst_resp_paddr", resp_paddr, 0);
        chk("arst_resp_cacheable", 32'(resp_cacheable), 0);
        chk("arst_resp_fault", 32'(resp_fault), 32'(F_NONE));
        chk("arst_bat_vaddr", bat_vaddr, 0);
        chk("arst_bat_priv", 32'(bat_privileged), 0);
        chk("arst_bat_rnw", 32'(bat_rnw), 1);
        @(negedge clk);
        reset = 1'b0;
        tlb_ack = 1'b1;
        tlb_paddr = 32'hDEAD_BEEF;
        @(negedge clk);
        tlb_ack = 1'b0;
        chk("late_ack_resp_valid", 32'(resp_valid), 0);
        chk("late_ack_req_ready", 32'(req_ready), 1);
        chk("late_ack_resp_paddr", resp_paddr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
